// File: rtl/simon_input_sequencer.sv
// simon_input_sequencer: gathers C (key, plaintext) beats, then replays them to Top as one gap-free C-cycle start burst.
// Latency: first start cycle is one clock after the edge that accepts the last beat; all Top-facing outputs registered.
// Backpressure: in_ready is high only in LOAD; the next block is accepted only after Top reports done_final.
module simon_input_sequencer #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int C = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_key,
    input  logic [M-1:0] in_pt,
    output logic [N-1:0] key,
    output logic [M-1:0] Plaintxt,
    output logic         start,
    input  logic         done_final,
    output logic         busy,
    output logic [7:0]   blocks_sent
);
    localparam int PW = $clog2(C);
    localparam logic [PW-1:0] LAST = PW'(C - 1);

    typedef enum logic [1:0] {LOAD, STREAM, WAIT_DONE} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]  rd_ptr, rd_ptr_nxt;
    logic [N+M-1:0] mem [C];
    logic [N+M-1:0] rd_dat;
    logic           start_nxt;
    logic [N-1:0]   key_nxt;
    logic [M-1:0]   pt_nxt;
    logic [7:0]     blocks_nxt;
    logic           wr_en;

    assign in_ready = (state == LOAD);
    assign busy     = (state == STREAM) || (state == WAIT_DONE);

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        start_nxt  = 1'b0;
        rd_dat     = '0;
        blocks_nxt = blocks_sent;
        wr_en      = 1'b0;
        if (flush) begin
            // A beat offered alongside flush is dropped, not written.
            state_nxt  = LOAD;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (wr_ptr == LAST) begin
                            // Entry 0 is already stored, so the burst can start on the very next cycle.
                            state_nxt  = STREAM;
                            wr_ptr_nxt = '0;
                            rd_ptr_nxt = '0;
                            rd_dat     = mem[0];
                            start_nxt  = 1'b1;
                        end else begin
                            wr_ptr_nxt = wr_ptr + PW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (rd_ptr == LAST) begin
                        state_nxt  = WAIT_DONE;
                        rd_ptr_nxt = '0;
                    end else begin
                        rd_ptr_nxt = rd_ptr + PW'(1);
                        rd_dat     = mem[rd_ptr_nxt];
                        start_nxt  = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (done_final) begin
                        state_nxt  = LOAD;
                        wr_ptr_nxt = '0;
                        rd_ptr_nxt = '0;
                        blocks_nxt = blocks_sent + 8'd1;
                    end
                end
                default: state_nxt = LOAD;
            endcase
        end
        {key_nxt, pt_nxt} = rd_dat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            start       <= 1'b0;
            key         <= '0;
            Plaintxt    <= '0;
            blocks_sent <= '0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            start       <= start_nxt;
            key         <= key_nxt;
            Plaintxt    <= pt_nxt;
            blocks_sent <= blocks_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {in_key, in_pt};
    end
endmodule

// File: tb/tb_simon_input_sequencer.sv
// Scoreboard bench: stimulus pushes expected replay pairs and burst lengths; a negedge monitor pops and compares.
module tb_simon_input_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_key = '0;
    logic [3:0] in_pt = '0;
    logic [7:0] key;
    logic [3:0] Plaintxt;
    logic       start;
    logic       done_final = 1'b0;
    logic       busy;
    logic [7:0] blocks_sent;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q [$];
    int          run_q [$];
    logic [7:0]  exp_blocks = 8'd0;
    logic [7:0]  cur_k [8];
    logic [3:0]  cur_p [8];

    simon_input_sequencer #(.N(8), .M(4), .C(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_pt(in_pt),
        .key(key), .Plaintxt(Plaintxt), .start(start), .done_final(done_final),
        .busy(busy), .blocks_sent(blocks_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one beat and returns one clock after it was accepted.
    task automatic send(input logic [7:0] k, input logic [3:0] p);
        int guard = 0;
        in_valid = 1'b1;
        in_key   = k;
        in_pt    = p;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Loads cur_k/cur_p; only the first npush pairs are expected to appear, in a burst of length npush.
    task automatic load_block(input int npush);
        for (int i = 0; i < npush; i++) exp_q.push_back({cur_k[i], cur_p[i]});
        run_q.push_back(npush);
        for (int i = 0; i < 8; i++) send(cur_k[i], cur_p[i]);
        check("start_latency", {31'd0, start}, 32'd1);
        check("in_ready_stream", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic fill(input int seed);
        for (int i = 0; i < 8; i++) begin
            cur_k[i] = 8'(seed * 8 + i * 3 + 1);
            cur_p[i] = 4'(seed + i);
        end
    endtask

    task automatic wait_burst_end();
        int guard = 0;
        while (start && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("burst_end_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_block();
        wait_burst_end();
        check("busy_wait", {31'd0, busy}, 32'd1);
        check("in_ready_wait", {31'd0, in_ready}, 32'd0);
        done_final = 1'b1;
        tick();
        done_final = 1'b0;
        exp_blocks = exp_blocks + 8'd1;
        check("blocks_sent", {24'd0, blocks_sent}, {24'd0, exp_blocks});
        check("in_ready_after_done", {31'd0, in_ready}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every start cycle must match the head of the scoreboard; each burst length too.
    initial begin
        int run;
        logic [11:0] e;
        run = 0;
        forever begin
            @(negedge clk);
            if (start && !reset) begin
                run++;
                if (exp_q.size() == 0) begin
                    check("unexpected_start", {20'd0, key, Plaintxt}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("burst_pair", {20'd0, key, Plaintxt}, {20'd0, e});
                end
            end else if (run > 0) begin
                if (run_q.size() == 0) check("unexpected_burst_len", run, 32'd0);
                else check("burst_len", run, run_q.pop_front());
                run = 0;
            end
        end
    end

    initial begin
        #2;
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_key", {24'd0, key}, 32'd0);
        check("rst_pt", {28'd0, Plaintxt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_blocks", {24'd0, blocks_sent}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors, back-to-back.
        cur_k = '{8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00};
        cur_p = '{4'h6, 4'h5, 4'h6, 4'h5, 4'h6, 4'h8, 4'h7, 4'h7};
        load_block(8);
        wait_burst_end();
        check("blocks_before_done", {24'd0, blocks_sent}, 32'd0);
        finish_block();

        // Same vectors with a 3-cycle gap; done_final pulses in LOAD and STREAM are ignored.
        for (int i = 0; i < 8; i++) exp_q.push_back({cur_k[i], cur_p[i]});
        run_q.push_back(8);
        for (int i = 0; i < 4; i++) send(cur_k[i], cur_p[i]);
        tick();
        done_final = 1'b1;
        tick();
        done_final = 1'b0;
        tick();
        check("done_in_load", {24'd0, blocks_sent}, {24'd0, exp_blocks});
        for (int i = 4; i < 8; i++) send(cur_k[i], cur_p[i]);
        check("gap_start_latency", {31'd0, start}, 32'd1);
        done_final = 1'b1;
        tick();
        done_final = 1'b0;
        check("done_in_stream", {24'd0, blocks_sent}, {24'd0, exp_blocks});
        finish_block();

        // Flush after 5 beats; a beat offered during flush is dropped.
        fill(3);
        for (int i = 0; i < 5; i++) send(cur_k[i], cur_p[i]);
        in_valid = 1'b1;
        in_key   = 8'hEE;
        in_pt    = 4'hE;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_load_busy", {31'd0, busy}, 32'd0);
        fill(4);
        load_block(8);
        finish_block();

        // in_valid held high through STREAM/WAIT_DONE: AA must become beat 0 of the next block only.
        fill(5);
        load_block(8);
        in_valid = 1'b1;
        in_key   = 8'hAA;
        in_pt    = 4'hA;
        finish_block();
        fill(6);
        cur_k[0] = 8'hAA;
        cur_p[0] = 4'hA;
        load_block(8);
        finish_block();

        // Flush on burst cycle 3: four pairs out, then LOAD.
        fill(7);
        load_block(4);
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_stream_start", {31'd0, start}, 32'd0);
        check("flush_stream_ready", {31'd0, in_ready}, 32'd1);
        check("flush_stream_blocks", {24'd0, blocks_sent}, {24'd0, exp_blocks});

        // Run blocks until the counter wraps past 255.
        while (exp_blocks != 8'd0) begin
            fill(int'(exp_blocks));
            load_block(8);
            finish_block();
        end
        check("blocks_wrap", {24'd0, blocks_sent}, 32'd0);

        // Asynchronous reset on burst cycle 3, between edges.
        fill(9);
        load_block(3);
        tick();
        tick();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_start", {31'd0, start}, 32'd0);
        check("async_rst_key", {24'd0, key}, 32'd0);
        check("async_rst_pt", {28'd0, Plaintxt}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        exp_blocks = 8'd0;
        fill(11);
        load_block(8);
        finish_block();

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("runs_empty", run_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simon_input_sequencer.md
Name: simon_input_sequencer

Overview:
Upstream feeder for the Simon cipher top (Top). It accepts one (key byte, plaintext nibble) pair per beat over a valid/ready handshake and buffers C pairs. It then replays them to Top as a gap-free burst of exactly C cycles with start held high. It waits for Top's done_final before accepting the next block, so Top never sees a partial or overlapping burst.

Parameters:
N, 8, key slice width per cycle (matches Top N)
M, 4, plaintext nibble width per cycle (matches Top M)
C, 8, beats per block / burst length (matches Top C); legal range 2..64

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous abort; discards the partial load or the burst in progress
in_valid  input  1  upstream pair valid
in_ready  output  1  sequencer can accept a pair
in_key  input  N  key slice for this beat
in_pt  input  M  plaintext nibble for this beat
key  output  N  to Top.key
Plaintxt  output  M  to Top.Plaintxt
start  output  1  to Top.start
done_final  input  1  from Top.done_final
busy  output  1  high in STREAM or WAIT_DONE
blocks_sent  output  8  count of completed blocks (done_final seen); wraps 255->0

Behaviour:
- Reset (async, active-high): state=LOAD, wr_ptr=0, rd_ptr=0, start=0, key=0, Plaintxt=0, busy=0, blocks_sent=0, in_ready=1 once reset deasserts. Buffer contents need not be cleared.
- Buffer: C entries of N+M bits. Pointers are clog2(C) bits. No wrap inside a block: pointers reset to 0 at each state entry.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid && in_ready at the clock edge, written to buf[wr_ptr], and wr_ptr increments.
  - On acceptance of beat C-1 (wr_ptr==C-1): go to STREAM and set in_ready=0 from the next cycle. No extra pairs are accepted.
  - in_valid low: hold state; gaps between beats are allowed.
- STREAM:
  - Outputs are registered. Start is high for exactly C consecutive cycles.
  - In cycle k (k=0..C-1): key=buf[k][N+M-1:M], Plaintxt=buf[k][M-1:0].
  - The first start cycle is the cycle immediately after the edge that accepted the last beat (load-to-start latency = 1 clock).
  - After cycle C-1, go to WAIT_DONE.
- WAIT_DONE:
  - start=0, key=0, Plaintxt=0, in_ready=0.
  - done_final sampled high: blocks_sent++, rd_ptr=0, wr_ptr=0, next state LOAD. in_ready=1 on the following cycle.
- done_final high in LOAD or STREAM: ignored, no count.
- flush:
  - Highest synchronous priority. Next state LOAD; pointers=0; start/key/Plaintxt=0; blocks_sent unchanged.
  - A beat presented in the same cycle as flush is dropped.
- in_ready is combinational from state only (no dependency on in_valid).
- Reset mid-burst: start drops to 0 asynchronously; the burst is not resumed.
- busy = (state==STREAM) || (state==WAIT_DONE).

Test Plan:
- Reset, then 8 back-to-back beats (19/6, 18/5, 11/6, 10/5, 09/6, 08/8, 01/7, 00/7) -> in_ready drops after beat 8; start high exactly 8 cycles starting the next cycle; key/Plaintxt replay the same order; start=0 after.
- Same 8 beats with in_valid toggled off for 3 cycles between beats 4 and 5 -> identical burst output; no duplicated or lost pair.
- Pulse done_final during LOAD and during STREAM -> ignored, blocks_sent stays 0. Pulse in WAIT_DONE -> blocks_sent=1, in_ready=1 next cycle. Repeat 256 blocks -> blocks_sent wraps to 0.
- flush after 5 beats, then load 8 new beats -> burst contains only the new 8 pairs.
- flush on burst cycle 3 -> start low next cycle; returns to LOAD; blocks_sent unchanged.
- Assert reset asynchronously mid-burst (between clock edges) -> start, key and Plaintxt go to 0 immediately; state LOAD, in_ready=1 after release.
- Keep in_valid high through STREAM/WAIT_DONE -> no beat is accepted until in_ready returns.
